// File: rtl/vga_timing_monitor_pkg.sv
// Shared constants, FSM state type and helpers for the VGA timing monitor.
// XGA defaults are kept here so the generator, the monitor and benches agree.
package vga_timing_monitor_pkg;

  localparam int unsigned XGA_H_TOTAL = 1344;
  localparam int unsigned XGA_H_SYNC  = 136;
  localparam int unsigned XGA_V_TOTAL = 806;
  localparam int unsigned XGA_V_SYNC  = 6;

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/vga_timing_monitor_if.sv
// Video stream bundle observed by the monitor.
// Stream semantics: no flow control; every pin is a level sampled on every pclk edge.
interface vga_timing_monitor_if #(
  parameter int unsigned CW = 4
);
  logic          hs;
  logic          vs;
  logic [CW-1:0] r;
  logic [CW-1:0] g;
  logic [CW-1:0] b;

  modport master (output hs, vs, r, g, b);
  modport slave  (input  hs, vs, r, g, b);
endinterface

// File: rtl/vga_timing_monitor_sync_edge_det.sv
// Two-flop sync capture with registered active/inactive edge pulses.
// The act level is taken from s2 so it lines up with the registered edge pulses.
module sync_edge_det
  import vga_timing_monitor_pkg::*;
#(
  parameter bit SYNC_POL = SYNC_ACTIVE_LOW
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic act,
  output logic act_edge,
  output logic inact_edge
);

  logic s1_q, s2_q, ae_q, ie_q;
  logic ae_d, ie_d;
  logic s1_act, s2_act;

  assign s1_act = (s1_q == SYNC_POL);
  assign s2_act = (s2_q == SYNC_POL);

  always_comb begin
    ae_d = s1_act & ~s2_act;
    ie_d = ~s1_act & s2_act;
  end

  // Pipeline resets to the inactive level so release never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= ~SYNC_POL;
      s2_q <= ~SYNC_POL;
      ae_q <= 1'b0;
      ie_q <= 1'b0;
    end else begin
      s1_q <= sig;
      s2_q <= s1_q;
      ae_q <= ae_d;
      ie_q <= ie_d;
    end
  end

  assign act        = s2_act;
  assign act_edge   = ae_q;
  assign inact_edge = ie_q;

endmodule

// File: rtl/vga_timing_monitor.sv
// VGA stream checker: measures hs/vs timing, checks blanking during sync,
// and freezes after FRAMES complete frames with sticky error flags.
module vga_timing_monitor
  import vga_timing_monitor_pkg::*;
#(
  parameter int unsigned H_TOTAL  = XGA_H_TOTAL,
  parameter int unsigned H_SYNC   = XGA_H_SYNC,
  parameter int unsigned V_TOTAL  = XGA_V_TOTAL,
  parameter int unsigned V_SYNC   = XGA_V_SYNC,
  parameter bit          SYNC_POL = SYNC_ACTIVE_LOW,
  parameter int unsigned CW       = 4,
  parameter int unsigned FRAMES   = 2
) (
  input  logic                   pclk,
  input  logic                   rst,
  vga_timing_monitor_if.slave    vid,
  output logic [7:0]             frame_cnt,
  output logic [CNT_W-1:0]       last_h_period,
  output logic                   locked,
  output logic                   done,
  output logic                   err_h_period,
  output logic                   err_h_width,
  output logic                   err_v_lines,
  output logic                   err_v_width,
  output logic                   err_blank,
  output logic                   err_any,
  output state_e                 state_dbg
);

  localparam logic [CNT_W-1:0] H_TOTAL_C   = CNT_W'(H_TOTAL);
  localparam logic [CNT_W-1:0] H_SYNC_C    = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_TOTAL_C   = CNT_W'(V_TOTAL);
  localparam logic [CNT_W-1:0] V_SYNC_C    = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_TIMEOUT_C = CNT_W'(2 * H_TOTAL);
  localparam logic [7:0]       FRAMES_C    = 8'(FRAMES);

  logic hs_act, hs_aedge, hs_iedge;
  logic vs_act, vs_aedge, vs_iedge;

  sync_edge_det #(.SYNC_POL(SYNC_POL)) u_hs_det (
    .clk(pclk), .rst(rst), .sig(vid.hs),
    .act(hs_act), .act_edge(hs_aedge), .inact_edge(hs_iedge)
  );

  sync_edge_det #(.SYNC_POL(SYNC_POL)) u_vs_det (
    .clk(pclk), .rst(rst), .sig(vid.vs),
    .act(vs_act), .act_edge(vs_aedge), .inact_edge(vs_iedge)
  );

  // Colour goes through the same two stages so it aligns with hs_act/vs_act.
  logic [3*CW-1:0] rgb_s1_q, rgb_s1_d;
  logic            rgb_nz_q, rgb_nz_d;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d, hw_q, hw_d, lcnt_q, lcnt_d, vw_q, vw_d;
  logic [CNT_W-1:0] last_h_q, last_h_d;
  logic [7:0]       frame_q, frame_d;
  logic             h_seen_q, h_seen_d;
  logic             e_hp_q, e_hp_d, e_hw_q, e_hw_d, e_vl_q, e_vl_d;
  logic             e_vw_q, e_vw_d, e_bl_q, e_bl_d, e_any_q, e_any_d;
  logic             measure;

  assign measure = (state_q == ST_MEASURE);

  always_comb begin
    rgb_s1_d = {vid.r, vid.g, vid.b};
    rgb_nz_d = |rgb_s1_q;
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    hw_d     = hw_q;
    lcnt_d   = lcnt_q;
    vw_d     = vw_q;
    last_h_d = last_h_q;
    frame_d  = frame_q;
    h_seen_d = h_seen_q;
    e_hp_d   = e_hp_q;
    e_hw_d   = e_hw_q;
    e_vl_d   = e_vl_q;
    e_vw_d   = e_vw_q;
    e_bl_d   = e_bl_q;

    if (state_q != ST_DONE) begin
      if (hs_aedge) begin
        hcnt_d   = CNT_W'(1);
        h_seen_d = 1'b1;
        if (h_seen_q) begin
          last_h_d = hcnt_q;
          if (measure && (hcnt_q != H_TOTAL_C)) e_hp_d = 1'b1;
        end
      end else if (hcnt_q < H_TIMEOUT_C) begin
        hcnt_d = hcnt_q + 1'b1;
      end
      if (measure && (hcnt_q >= H_TIMEOUT_C)) e_hp_d = 1'b1;

      if (hs_aedge)    hw_d = CNT_W'(1);
      else if (hs_act) hw_d = sat_inc(hw_q);
      if (measure && hs_iedge && (hw_q != H_SYNC_C)) e_hw_d = 1'b1;

      // A coincident hs edge opens the new frame, never closes the old one.
      if (vs_aedge) begin
        lcnt_d = hs_aedge ? CNT_W'(1) : '0;
        vw_d   = hs_aedge ? CNT_W'(1) : '0;
        if (measure) begin
          if (lcnt_q != V_TOTAL_C) e_vl_d = 1'b1;
          frame_d = frame_q + 8'd1;
          if (frame_q + 8'd1 == FRAMES_C) state_d = ST_DONE;
        end else begin
          state_d = ST_MEASURE;
        end
      end else begin
        if (hs_aedge)           lcnt_d = sat_inc(lcnt_q);
        if (hs_aedge && vs_act) vw_d   = sat_inc(vw_q);
      end
      if (measure && vs_iedge && (vw_q != V_SYNC_C)) e_vw_d = 1'b1;

      if (measure && (hs_act || vs_act) && rgb_nz_q) e_bl_d = 1'b1;
    end

    e_any_d = e_hp_d | e_hw_d | e_vl_d | e_vw_d | e_bl_d;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      rgb_s1_q <= '0;
      rgb_nz_q <= 1'b0;
      state_q  <= ST_IDLE;
      hcnt_q   <= '0;
      hw_q     <= '0;
      lcnt_q   <= '0;
      vw_q     <= '0;
      last_h_q <= '0;
      frame_q  <= '0;
      h_seen_q <= 1'b0;
      e_hp_q   <= 1'b0;
      e_hw_q   <= 1'b0;
      e_vl_q   <= 1'b0;
      e_vw_q   <= 1'b0;
      e_bl_q   <= 1'b0;
      e_any_q  <= 1'b0;
    end else begin
      rgb_s1_q <= rgb_s1_d;
      rgb_nz_q <= rgb_nz_d;
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      hw_q     <= hw_d;
      lcnt_q   <= lcnt_d;
      vw_q     <= vw_d;
      last_h_q <= last_h_d;
      frame_q  <= frame_d;
      h_seen_q <= h_seen_d;
      e_hp_q   <= e_hp_d;
      e_hw_q   <= e_hw_d;
      e_vl_q   <= e_vl_d;
      e_vw_q   <= e_vw_d;
      e_bl_q   <= e_bl_d;
      e_any_q  <= e_any_d;
    end
  end

  assign frame_cnt     = frame_q;
  assign last_h_period = last_h_q;
  assign locked        = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign err_h_period  = e_hp_q;
  assign err_h_width   = e_hw_q;
  assign err_v_lines   = e_vl_q;
  assign err_v_width   = e_vw_q;
  assign err_blank     = e_bl_q;
  assign err_any       = e_any_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor on a scaled-down raster
// (20 pclk/line, 4 hs, 10 lines/frame, 2 vs lines, active-low sync).
module tb_vga_timing_monitor;
  import vga_timing_monitor_pkg::*;

  localparam int H  = 20;
  localparam int HS = 4;
  localparam int V  = 10;
  localparam int VS = 2;
  localparam int FR = 2;
  localparam int CW = 4;

  // ---------------- clock / reset ----------------
  logic pclk = 1'b0;
  logic rst  = 1'b1;
  always #5 pclk = ~pclk;

  vga_timing_monitor_if #(.CW(CW)) vid ();

  logic [7:0]  frame_cnt;
  logic [15:0] last_h_period;
  logic        locked, done;
  logic        err_h_period, err_h_width, err_v_lines, err_v_width, err_blank, err_any;
  state_e      state_dbg;

  vga_timing_monitor #(
    .H_TOTAL(H), .H_SYNC(HS), .V_TOTAL(V), .V_SYNC(VS),
    .SYNC_POL(SYNC_ACTIVE_LOW), .CW(CW), .FRAMES(FR)
  ) dut (
    .pclk(pclk), .rst(rst), .vid(vid),
    .frame_cnt(frame_cnt), .last_h_period(last_h_period),
    .locked(locked), .done(done),
    .err_h_period(err_h_period), .err_h_width(err_h_width),
    .err_v_lines(err_v_lines), .err_v_width(err_v_width),
    .err_blank(err_blank), .err_any(err_any), .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_errs(input string tag, input bit hp, input bit hw, input bit vl,
                          input bit vw, input bit bl);
    chk({tag, ".err_h_period"}, 32'(err_h_period), 32'(hp));
    chk({tag, ".err_h_width"},  32'(err_h_width),  32'(hw));
    chk({tag, ".err_v_lines"},  32'(err_v_lines),  32'(vl));
    chk({tag, ".err_v_width"},  32'(err_v_width),  32'(vw));
    chk({tag, ".err_blank"},    32'(err_blank),    32'(bl));
    chk({tag, ".err_any"},      32'(err_any),      32'(hp | hw | vl | vw | bl));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".frame_cnt"}, 32'(frame_cnt), 32'd0);
    chk({tag, ".last_h"},    32'(last_h_period), 32'd0);
    chk({tag, ".locked"},    32'(locked), 32'd0);
    chk({tag, ".done"},      32'(done), 32'd0);
    chk({tag, ".state"},     32'(state_dbg), 32'(ST_IDLE));
    chk_errs(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Final state after a complete FR-frame run.
  task automatic chk_done(input string tag, input bit hp, input bit hw, input bit vl,
                          input bit vw, input bit bl);
    chk({tag, ".done"},      32'(done), 32'd1);
    chk({tag, ".locked"},    32'(locked), 32'd1);
    chk({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(FR));
    chk({tag, ".state"},     32'(state_dbg), 32'(ST_DONE));
    chk_errs(tag, hp, hw, vl, vw, bl);
  endtask

  // ---------------- drivers ----------------
  // One pclk of stream; pins change on the falling edge, away from sampling.
  task automatic pix(input bit hs_a, input bit vs_a, input logic [CW-1:0] rv);
    @(negedge pclk);
    vid.hs = ~hs_a;
    vid.vs = ~vs_a;
    vid.r  = rv;
    vid.g  = (hs_a || vs_a) ? 4'h0 : 4'h5;
    vid.b  = (hs_a || vs_a) ? 4'h0 : 4'h9;
  endtask

  // Cycles [from, len) of a line; glitch puts r=F on cycle 1 (inside hs).
  task automatic line_part(input int len, input int hw, input bit vsa, input bit glitch,
                           input int from);
    bit ha;
    logic [CW-1:0] rv;
    for (int i = from; i < len; i++) begin
      ha = (i < hw);
      if (ha || vsa) rv = (glitch && i == 1) ? 4'hF : 4'h0;
      else           rv = 4'hA;
      pix(ha, vsa, rv);
    end
  endtask

  // Lines [from_line, nlines) of a frame; odd_line gets its own length/width/glitch.
  task automatic frame(input int from_line, input int nlines, input int vsw,
                       input int odd_line, input int odd_len, input int odd_hw,
                       input bit odd_glitch);
    for (int l = from_line; l < nlines; l++) begin
      if (l == odd_line) line_part(odd_len, odd_hw, l < vsw, odd_glitch, 0);
      else               line_part(H, HS, l < vsw, 1'b0, 0);
    end
  endtask

  task automatic clean(input int from_line, input int nlines);
    frame(from_line, nlines, VS, -1, H, HS, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge pclk);
    rst = 1'b1;
    vid.hs = 1'b1; vid.vs = 1'b1;
    vid.r = '0; vid.g = '0; vid.b = '0;
    repeat (3) @(negedge pclk);
    rst = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    vid.hs = 1'b1; vid.vs = 1'b1;
    vid.r = '0; vid.g = '0; vid.b = '0;

    // Clean stream: lock latency, frame count, done latency, freeze.
    do_reset();
    chk_zero("reset");
    pix(1, 1, 0); pix(1, 1, 0); pix(1, 1, 0);
    chk("lock_at_2clk", 32'(locked), 32'd0);
    pix(1, 1, 0);
    chk("lock_at_3clk", 32'(locked), 32'd1);
    chk("state_measure", 32'(state_dbg), 32'(ST_MEASURE));
    line_part(H, HS, 1'b1, 1'b0, 4);
    clean(1, V);
    line_part(H, HS, 1'b1, 1'b0, 0);
    chk("frame_cnt_mid", 32'(frame_cnt), 32'd1);
    chk("done_mid", 32'(done), 32'd0);
    clean(1, V);
    pix(1, 1, 0); pix(1, 1, 0); pix(1, 1, 0);
    chk("done_at_2clk", 32'(done), 32'd0);
    pix(1, 1, 0);
    chk("done_at_3clk", 32'(done), 32'd1);
    line_part(H, HS, 1'b1, 1'b0, 4);
    line_part(30, HS, 1'b1, 1'b1, 0);
    line_part(H, HS, 1'b0, 1'b0, 0);
    chk_done("clean", 0, 0, 0, 0, 0);
    chk("clean.last_h", 32'(last_h_period), 32'(H));

    // One 21-cycle line in frame 2: flag appears 3 pclk after closing hs edge.
    do_reset();
    clean(0, V);
    clean(0, 3);
    line_part(H + 1, HS, 1'b0, 1'b0, 0);
    pix(1, 0, 0); pix(1, 0, 0); pix(1, 0, 0);
    chk("long_line_at_2clk", 32'(err_h_period), 32'd0);
    pix(1, 0, 0);
    chk("long_line_at_3clk", 32'(err_h_period), 32'd1);
    chk("long_line.last_h", 32'(last_h_period), 32'(H + 1));
    line_part(H, HS, 1'b0, 1'b0, 4);
    clean(5, V);
    clean(0, 2);
    chk_done("long_line", 1, 0, 0, 0, 0);

    // hs width one short.
    do_reset();
    clean(0, V);
    frame(0, V, VS, 5, H, HS - 1, 1'b0);
    clean(0, 2);
    chk_done("short_hs", 0, 1, 0, 0, 0);

    // vs width one line short.
    do_reset();
    clean(0, V);
    frame(0, V, VS - 1, -1, H, HS, 1'b0);
    clean(0, 2);
    chk_done("short_vs", 0, 0, 0, 1, 0);

    // Frame one line short: flagged only at the closing vs edge.
    do_reset();
    clean(0, V);
    clean(0, V - 1);
    chk("short_frame_before_vs", 32'(err_v_lines), 32'd0);
    clean(0, 2);
    chk_done("short_frame", 0, 0, 1, 0, 0);

    // Colour during sync: ignored before lock, flagged once locked.
    do_reset();
    line_part(H, HS, 1'b0, 1'b1, 0);
    line_part(H, HS, 1'b0, 1'b1, 0);
    line_part(H, HS, 1'b0, 1'b1, 0);
    chk("blank_idle.err_blank", 32'(err_blank), 32'd0);
    chk("blank_idle.locked", 32'(locked), 32'd0);
    clean(0, V);
    frame(0, V, VS, 4, H, HS, 1'b1);
    chk_errs("blank_locked", 0, 0, 0, 0, 1);
    clean(0, 2);
    chk_done("blank", 0, 0, 0, 0, 1);

    // hs stuck inactive past 2*H_TOTAL, then reset mid-frame and relock.
    do_reset();
    clean(0, V);
    clean(0, 4);
    repeat (45) pix(0, 0, 0);
    chk_errs("hs_timeout", 1, 0, 0, 0, 0);
    chk("hs_timeout.done", 32'(done), 32'd0);
    do_reset();
    chk_zero("mid_reset");
    clean(0, V);
    clean(0, V);
    clean(0, 2);
    chk_done("relock", 0, 0, 0, 0, 0);
    chk("relock.last_h", 32'(last_h_period), 32'(H));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
